// File: rtl/iob_timer_sched.sv
// rtl/iob_timer_sched.sv - multi-channel alarm scheduler sharing one counter and one round-robin comparator
// Optional tick prescaler at address 5: define TIMER_SCHED_PRESCALER_EN.
module iob_timer_sched #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int N_CH   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   rdata,
  output logic                ready,
  output logic                irq,
  output logic [N_CH-1:0]     fire
);

  localparam int               PTR_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [31:0]      CH_END   = 32'(8 + 2 * N_CH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_CH - 1);

  logic              run;
  logic [DATA_W-1:0] count;
  logic [N_CH-1:0]   status;
  logic [N_CH-1:0]   irq_en;
  logic [N_CH-1:0]   arm;
  logic [DATA_W-1:0] deadline [N_CH];
  logic [DATA_W-1:0] period   [N_CH];
  logic [PTR_W-1:0]  ptr;

  logic [31:0]       addr_w;
  logic              wr;
  logic              in_ch;
  logic [PTR_W-1:0]  ch_sel;
  logic              wr_ctrl;
  logic              cnt_clr;
  logic              wr_status;
  logic              wr_irq_en;
  logic              wr_arm;
  logic [N_CH-1:0]   wr_dl;
  logic [N_CH-1:0]   wr_per;
  logic              tick;
  logic [DATA_W-1:0] lag;
  logic              due;
  logic [N_CH-1:0]   due_vec;
  logic [DATA_W-1:0] rd_val;

  assign addr_w    = 32'(address);
  assign wr        = valid && (wstrb != '0);
  assign in_ch     = (addr_w >= 32'd8) && (addr_w < CH_END);
  assign ch_sel    = PTR_W'((addr_w - 32'd8) >> 1);
  assign wr_ctrl   = wr && (addr_w == 32'd0);
  assign cnt_clr   = wr_ctrl && wdata[1];
  assign wr_status = wr && (addr_w == 32'd2);
  assign wr_irq_en = wr && (addr_w == 32'd3);
  assign wr_arm    = wr && (addr_w == 32'd4);
  assign wr_dl     = (wr && in_ch && !addr_w[0]) ? (N_CH'(1) << ch_sel) : '0;
  assign wr_per    = (wr && in_ch &&  addr_w[0]) ? (N_CH'(1) << ch_sel) : '0;

  // Deadline counts as reached when it lies in the half-range window behind COUNT.
  assign lag     = count - deadline[ptr];
  assign due     = arm[ptr] && !lag[DATA_W-1];
  assign due_vec = due ? (N_CH'(1) << ptr) : '0;

  assign irq = |(status & irq_en);

`ifdef TIMER_SCHED_PRESCALER_EN
  logic [15:0] prescale;
  logic [15:0] pcnt;

  assign tick = run && (pcnt >= prescale);

  always_ff @(posedge clk) begin
    if (rst) begin
      prescale <= '0;
      pcnt     <= '0;
    end else begin
      if (wr && (addr_w == 32'd5)) prescale <= wdata[15:0];
      if (wr_ctrl)  pcnt <= '0;
      else if (run) pcnt <= tick ? 16'd0 : pcnt + 16'd1;
    end
  end
`else
  assign tick = run;
`endif

  always_comb begin
    rd_val = '0;
    case (addr_w)
      32'd0: rd_val = DATA_W'(run);
      32'd1: rd_val = count;
      32'd2: rd_val = DATA_W'(status);
      32'd3: rd_val = DATA_W'(irq_en);
      32'd4: rd_val = DATA_W'(arm);
`ifdef TIMER_SCHED_PRESCALER_EN
      32'd5: rd_val = DATA_W'(prescale);
`endif
      default: begin
        if (in_ch) rd_val = addr_w[0] ? period[ch_sel] : deadline[ch_sel];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run    <= 1'b0;
      count  <= '0;
      status <= '0;
      irq_en <= '0;
      arm    <= '0;
      ptr    <= '0;
      fire   <= '0;
      ready  <= 1'b0;
      rdata  <= '0;
      for (int k = 0; k < N_CH; k++) begin
        deadline[k] <= '0;
        period[k]   <= '0;
      end
    end else begin
      ready <= valid;
      rdata <= valid ? rd_val : '0;
      ptr   <= (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);
      fire  <= due_vec;

      // Hardware set is OR-ed after the clear so it survives a simultaneous W1C.
      status <= (status & ~(wr_status ? wdata[N_CH-1:0] : '0)) | due_vec;

      if (due && (period[ptr] == '0)) arm[ptr] <= 1'b0;
      if (wr_arm) arm <= wdata[N_CH-1:0];

      for (int k = 0; k < N_CH; k++) begin
        if (due_vec[k] && (period[k] != '0)) deadline[k] <= deadline[k] + period[k];
        if (wr_dl[k])  deadline[k] <= wdata;
        if (wr_per[k]) period[k]   <= wdata;
      end

      if (cnt_clr)   count <= '0;
      else if (tick) count <= count + DATA_W'(1);

      if (wr_ctrl)   run    <= wdata[0];
      if (wr_irq_en) irq_en <= wdata[N_CH-1:0];
    end
  end

endmodule

// File: tb/tb_iob_timer_sched.sv
// tb/tb_iob_timer_sched.sv - scoreboard bench for iob_timer_sched with a transaction-level reference model
module tb_iob_timer_sched;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int N_CH   = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              valid = 1'b0;
  logic [ADDR_W-1:0] address = '0;
  logic [31:0]       wdata = '0;
  logic [3:0]        wstrb = '0;
  logic [31:0]       rdata;
  logic              ready;
  logic              irq;
  logic [N_CH-1:0]   fire;

  iob_timer_sched #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_CH(N_CH)) dut (
    .clk(clk), .rst(rst), .valid(valid), .address(address), .wdata(wdata),
    .wstrb(wstrb), .rdata(rdata), .ready(ready), .irq(irq), .fire(fire)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
    end
  endtask

  typedef struct {int cyc; bit is_rd; int addr; logic [31:0] val;} rd_t;
  typedef struct {int cyc; logic [N_CH-1:0] vec;} fire_t;
  rd_t   exp_rd[$];
  fire_t exp_fire[$];
  bit    exp_irq[$];

  // Reference state: what software would see in each register.
  bit          m_run;
  logic [31:0] m_count;
  logic [3:0]  m_status, m_irq_en, m_arm;
  logic [31:0] m_dl [N_CH];
  logic [31:0] m_per [N_CH];
  int          m_pc;
  int          m_cyc = 0;
  logic [15:0] m_pre, m_pcnt;

  function automatic logic [31:0] m_read(int a);
    case (a)
      0: return {31'b0, m_run};
      1: return m_count;
      2: return {28'b0, m_status};
      3: return {28'b0, m_irq_en};
      4: return {28'b0, m_arm};
`ifdef TIMER_SCHED_PRESCALER_EN
      5: return {16'b0, m_pre};
`endif
      default: if (a >= 8 && a < 8 + 2 * N_CH) return (a % 2 == 1) ? m_per[(a-8)/2] : m_dl[(a-8)/2];
    endcase
    return 32'h0;
  endfunction

  function automatic bit m_due_next(int k);
    logic [31:0] lag;
    lag = m_count - m_dl[k];
    return (m_pc % N_CH == k) && m_arm[k] && !lag[31];
  endfunction

  task automatic step(input bit r, input bit v, input int a, input logic [31:0] wd, input bit w,
                      input bit use_exp = 1'b0, input logic [31:0] exp_val = 32'h0);
    int          k;
    bit          due, tick;
    logic [31:0] lag, n_count;
    logic [3:0]  n_status, n_arm, set;
    logic [31:0] n_dl [N_CH];
    logic [15:0] n_pcnt;
    rst     = r;
    valid   = v;
    address = ADDR_W'(a);
    wdata   = wd;
    wstrb   = w ? 4'($urandom_range(1, 15)) : 4'h0;
    m_cyc++;
    if (r) begin
      m_run = 0; m_count = 0; m_status = 0; m_irq_en = 0; m_arm = 0; m_pc = 0;
      m_pre = 0; m_pcnt = 0;
      for (int i = 0; i < N_CH; i++) begin m_dl[i] = 0; m_per[i] = 0; end
    end else begin
      if (v) exp_rd.push_back('{cyc: m_cyc, is_rd: !w, addr: a, val: use_exp ? exp_val : m_read(a)});
      k = m_pc % N_CH;
      m_pc++;
      lag = m_count - m_dl[k];
      due = m_arm[k] && !lag[31];
      n_status = m_status; n_arm = m_arm; n_dl = m_dl; set = 0;
      if (due) begin
        set = 4'(1 << k);
        n_status = n_status | set;
        exp_fire.push_back('{cyc: m_cyc, vec: set});
        if (m_per[k] != 0) n_dl[k] = m_dl[k] + m_per[k];
        else n_arm[k] = 1'b0;
      end
`ifdef TIMER_SCHED_PRESCALER_EN
      tick = m_run && (m_pcnt >= m_pre);
      n_pcnt = !m_run ? m_pcnt : (tick ? 16'd0 : m_pcnt + 16'd1);
`else
      tick = m_run;
      n_pcnt = 0;
`endif
      n_count = tick ? m_count + 1 : m_count;
      if (v && w) begin
        case (a)
          0: begin m_run = wd[0]; n_pcnt = 0; if (wd[1]) n_count = 0; end
          2: n_status = (m_status & ~wd[3:0]) | set;
          3: m_irq_en = wd[3:0];
          4: n_arm = wd[3:0];
`ifdef TIMER_SCHED_PRESCALER_EN
          5: m_pre = wd[15:0];
`endif
          default: if (a >= 8 && a < 8 + 2 * N_CH) begin
            if (a % 2 == 1) m_per[(a-8)/2] = wd;
            else n_dl[(a-8)/2] = wd;
          end
        endcase
      end
      m_count = n_count; m_status = n_status; m_arm = n_arm; m_dl = n_dl; m_pcnt = n_pcnt;
    end
    exp_irq.push_back(|(m_status & m_irq_en));
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask
  task automatic wr(input int a, input logic [31:0] d);
    step(0, 1, a, d, 1);
  endtask
  task automatic rd(input int a);
    step(0, 1, a, 0, 0);
  endtask
  task automatic rdx(input int a, input logic [31:0] e);
    step(0, 1, a, 0, 0, 1, e);
  endtask
  task automatic wait_due(input int k);
    int n = 0;
    while (!m_due_next(k) && n < 64) begin idle(1); n++; end
    chk($sformatf("wait_due ch%0d reached", k), 32'(m_due_next(k)), 32'd1);
  endtask
  task automatic run_until(input logic [31:0] c);
    int n = 0;
    while (m_count < c && n < 4000) begin idle(1); n++; end
    chk("run_until count reached", 32'(m_count >= c), 32'd1);
  endtask

  // Monitor: pops expectations whenever the DUT presents ready or fire, and checks irq every cycle.
  int    mon_cyc = 0;
  rd_t   re;
  fire_t fe;
  always @(posedge clk) begin
    #1;
    mon_cyc++;
    if (exp_irq.size() > 0) chk("irq", 32'(irq), 32'(exp_irq.pop_front()));
    if (fire != '0 || (exp_fire.size() > 0 && exp_fire[0].cyc == mon_cyc)) begin
      if (exp_fire.size() > 0 && exp_fire[0].cyc == mon_cyc) begin
        fe = exp_fire.pop_front();
        chk($sformatf("fire cyc %0d", mon_cyc), 32'(fire), 32'(fe.vec));
      end else chk($sformatf("unexpected fire cyc %0d", mon_cyc), 32'(fire), 32'h0);
    end
    if (ready || (exp_rd.size() > 0 && exp_rd[0].cyc == mon_cyc)) begin
      if (exp_rd.size() > 0 && exp_rd[0].cyc == mon_cyc) begin
        re = exp_rd.pop_front();
        chk($sformatf("ready cyc %0d", mon_cyc), 32'(ready), 32'd1);
        if (re.is_rd) chk($sformatf("rdata addr %0d cyc %0d", re.addr, mon_cyc), rdata, re.val);
      end else chk($sformatf("unexpected ready cyc %0d", mon_cyc), 32'(ready), 32'h0);
    end
  end

  initial begin
    int          r, a, k;
    logic [31:0] x;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);

    // Reset mid-run discards state.
    wr(8, 40); wr(4, 1); wr(0, 3);
    run_until(20);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    rdx(1, 0); rdx(4, 0); rdx(2, 0);

    // One-shot on channel 0.
    wr(0, 2); wr(8, 100); wr(9, 0); wr(4, 1); wr(3, 1); wr(0, 1);
    run_until(110);
    rdx(4, 0); rdx(2, 1);
    wr(2, 1); rdx(2, 0);

    // Periodic on channel 1.
    wr(0, 2); wr(10, 50); wr(11, 20); wr(4, 2); wr(0, 1);
    run_until(100);
    rdx(10, 110); rdx(4, 2);

    // Half-range window around a stopped counter.
    wr(0, 0); wr(4, 0); wr(2, 15);
    x = m_count;
    wr(12, 32'hFFFF_FFF0); wr(13, 0); wr(14, x + 32'h7FFF_FFFF); wr(15, 0); wr(4, 12);
    idle(8);
    rdx(4, 8); rdx(2, 4);

    // Collisions between bus writes and scan updates.
    wr(4, 0); wr(2, 15); wr(12, m_count); wr(13, 0); wr(4, 4);
    wait_due(2); wr(2, 4); rdx(2, 4);
    wr(2, 15); wr(8, m_count); wr(9, 0); wr(4, 1);
    wait_due(0); wr(4, 1); rdx(4, 1);
    wr(10, m_count); wr(11, 20); wr(4, 2);
    wait_due(1); x = m_count + 1000; wr(10, x); rdx(10, x);

    // Tick rate.
`ifdef TIMER_SCHED_PRESCALER_EN
    wr(5, 3); rdx(5, 3);
`else
    wr(5, 7); rdx(5, 0);
`endif
    wr(4, 0); wr(0, 3);
    idle(100);
`ifdef TIMER_SCHED_PRESCALER_EN
    rdx(1, 25);
    wr(5, 0);
`else
    rdx(1, 100);
`endif
    rdx(0, 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 199));
      k = int'($urandom_range(0, N_CH - 1));
      if (r < 70) idle(1);
      else if (r < 110) rd(int'($urandom_range(0, 31)));
      else if (r < 128) wr(8 + 2 * k, ($urandom_range(0, 3) == 0) ? m_count - $urandom_range(0, 30)
                                                                   : m_count + $urandom_range(0, 80));
      else if (r < 140) wr(9 + 2 * k, ($urandom_range(0, 2) == 0) ? 32'h0 : 32'($urandom_range(1, 40)));
      else if (r < 155) wr(4, 32'($urandom_range(0, 15)));
      else if (r < 167) wr(2, 32'($urandom_range(0, 15)));
      else if (r < 175) wr(3, 32'($urandom_range(0, 15)));
      else if (r < 187) wr(0, ($urandom_range(0, 9) == 0) ? 32'd3 : 32'd1);
      else if (r < 198) begin
        a = int'($urandom_range(0, 31));
        wr(a, (a == 5) ? 32'($urandom_range(0, 3)) : $urandom);
      end else step(1, 0, 0, 0, 0);
    end

    idle(10);
    chk("read queue drained", 32'(exp_rd.size()), 32'd0);
    chk("fire queue drained", 32'(exp_fire.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/iob_timer_sched.md
Name: iob_timer_sched

Overview:
- Multi-channel alarm scheduler built around one shared free-running counter.
- Software programs up to N_CH absolute deadlines, one-shot or periodic.
- A single comparator is time-multiplexed round-robin across the channels. Matching channels raise status bits, a per-channel fire pulse and a maskable interrupt.
- Sits on the native peripheral bus (valid/address/wdata/wstrb/rdata/ready) next to the plain timer peripheral.

Parameters:
- DATA_W, 32, counter, deadline, period and bus data width.
- ADDR_W, 5, word address width; must cover 9+2*(N_CH-1).
- N_CH, 4, number of alarm channels, 1..8.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- valid  in  1  bus request.
- address  in  ADDR_W  word address.
- wdata  in  DATA_W  write data.
- wstrb  in  DATA_W/8  write strobes; any nonzero value means full-word write, zero means read.
- rdata  out  DATA_W  read data, valid while ready=1.
- ready  out  1  bus acknowledge.
- irq  out  1  |(STATUS & IRQ_EN).
- fire  out  N_CH  one-cycle pulse per channel on match.

Behaviour:
- Reset: one clock and one reset. Reset is synchronous and active-high; the clock port is clk and the reset port is rst. Reset zeroes every register, the counter and the scan pointer, and drives rdata=0, ready=0, irq=0, fire=0. Reset asserted mid-operation discards any in-flight access and any pending rearm.
- Bus: ready=1 exactly one cycle after any cycle with valid=1. The write takes effect at that edge, and rdata is registered and presented with ready. Back-to-back valid is allowed.
- Register map:
  - 0 CTRL rw: bit0 RUN; bit1 CNT_CLR is write-1 pulse, reads 0.
  - 1 COUNT r.
  - 2 STATUS r / write-1-to-clear, bits[N_CH-1:0].
  - 3 IRQ_EN rw.
  - 4 ARM rw bitmask.
  - 5 PRESCALE (optional feature).
  - 8+2k DEADLINE_k rw.
  - 9+2k PERIOD_k rw.
  - Unmapped addresses read 0; writes to them are ignored.
- Counter: increments by 1 per tick while RUN=1 and wraps modulo 2^DATA_W. CNT_CLR zeroes it and has priority over the increment.
- Scan pointer ptr: cycles 0..N_CH-1, advancing one step every clock regardless of RUN. Worst-case detection latency is N_CH cycles after COUNT reaches the deadline.
- At ptr=k, the channel is due if ARM[k]=1 and MSB of (COUNT - DEADLINE_k) mod 2^DATA_W is 0, i.e. the deadline is not in the future within a half-range window. When due, at the next edge:
  - STATUS[k] is set.
  - fire[k] pulses for 1 cycle.
  - If PERIOD_k != 0: DEADLINE_k += PERIOD_k (modulo), and ARM[k] stays 1.
  - If PERIOD_k = 0: ARM[k] is cleared.
- Only one channel can fire per cycle.
- A deadline already in the past when armed fires on its next scan slot, even with RUN=0.
- A periodic channel that falls behind fires once per scan visit until it catches up. No fire events are dropped or merged.
- Collisions in the same cycle:
  - Bus write to DEADLINE_k or ARM vs scan update of k: the bus write wins.
  - Hardware set of STATUS[k] vs W1C of bit k: the set wins.
  - Bus write to CTRL CNT_CLR vs increment: the clear wins.
- irq: combinational from the STATUS and IRQ_EN registers, no extra latency.

Optional Feature:
- Macro: TIMER_SCHED_PRESCALER_EN.
- Defined: address 5 is PRESCALE rw, 16 bits, zero-extended on read. A prescale counter increments every clock while RUN=1; on reaching PRESCALE it wraps to 0 and generates a tick.
  - PRESCALE=0 means one tick per clock.
  - CNT_CLR and writing CTRL also zero the prescale counter.
- Undefined: a tick occurs every clock while RUN=1; address 5 reads 0 and writes to it are ignored; no prescale logic is instantiated.

Test Plan:
1. Run with DEADLINE0=40, then assert rst for 2 cycles at COUNT=20 -> next cycle COUNT=0, ARM=0, STATUS=0, irq=0, ready=0, fire=0.
2. One-shot: CNT_CLR; DEADLINE0=100, PERIOD0=0, ARM=1, IRQ_EN=1, RUN=1 -> fire[0] pulses once with COUNT in 100..104; ARM reads 0; irq=1. Write STATUS=1 -> irq=0 next cycle.
3. Periodic: DEADLINE1=50, PERIOD1=20, ARM=2 -> fire[1] near COUNT 50, 70 and 90; DEADLINE1 reads 110 afterwards; ARM still 2.
4. Wrap window, with COUNT=10:
   - DEADLINE2=0xFFFF_FFF0, ARM=4 -> fires within 4 cycles.
   - DEADLINE3=10+0x7FFF_FFFF -> no fire.
5. Collisions:
   - W1C STATUS[2] in the cycle hardware sets it -> STATUS[2] stays 1.
   - Write ARM=1 in the cycle one-shot ch0 clears it -> ARM[0]=1.
   - Write DEADLINE1 in its rearm cycle -> written value kept.
6. With TIMER_SCHED_PRESCALER_EN: PRESCALE=3, CNT_CLR, RUN=1 for 100 clocks -> COUNT=25. Without the macro: COUNT=100, and address 5 reads 0.
